// File: rtl/seq_det_pkg.sv
// Shared constants, decode enum and width helper for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned SEQ_LEN_MAX = 32;
  localparam int unsigned FILL_EMPTY  = 0;

  typedef enum logic [1:0] {
    OpHold,
    OpSample,
    OpLoad
  } op_e;

  // Bits needed to hold any value 0..n (n itself included).
  function automatic int unsigned clog2p1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = n; v != 0; v = v >> 1) begin
      w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Stream, pattern-reload and status signals of the serial pattern detector.
interface seq_detect_param_if #(
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned CNT_W   = 8
);

  localparam int unsigned PW = seq_det_pkg::clog2p1(SEQ_LEN);

  logic               din_valid;
  logic               din;
  logic               pat_load;
  logic [SEQ_LEN-1:0] pat_in;
  logic               cnt_clr;
  logic               d_out;
  logic [CNT_W-1:0]   match_cnt;
  logic [PW-1:0]      p_state;

  modport master (
    output din_valid, din, pat_load, pat_in, cnt_clr,
    input  d_out, match_cnt, p_state
  );

  modport slave (
    input  din_valid, din, pat_load, pat_in, cnt_clr,
    output d_out, match_cnt, p_state
  );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector: reloadable pattern, optional overlap,
// registered one-cycle match pulse and saturating match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned        SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0] DEF_PATTERN = 4'b1001,
  parameter bit                 OVERLAP     = 1'b1,
  parameter int unsigned        CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_param_if.slave   bus
);

  localparam int unsigned   PW         = clog2p1(SEQ_LEN);
  localparam logic [PW-1:0] FILL_FULL  = PW'(SEQ_LEN);
  localparam logic [PW-1:0] FILL_START = PW'(FILL_EMPTY);

  logic [SEQ_LEN-1:0] pattern_q, pattern_d;
  logic [SEQ_LEN-1:0] hist_q, hist_d, hist_n;
  logic [PW-1:0]      fill_q, fill_d, fill_n;
  logic               d_out_q, d_out_d;
  logic               hit;
  op_e                op;

  always_comb begin
    op = OpHold;
    if (bus.pat_load) begin
      op = OpLoad;
    end else if (bus.din_valid) begin
      op = OpSample;
    end
  end

  assign hist_n = {hist_q[SEQ_LEN-2:0], bus.din};
  assign fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    d_out_d   = 1'b0;
    hit       = 1'b0;
    unique case (op)
      OpLoad: begin
        // History is discarded so no match can straddle a pattern change.
        pattern_d = bus.pat_in;
        hist_d    = '0;
        fill_d    = FILL_START;
      end
      OpSample: begin
        hit     = (fill_n == FILL_FULL) && (hist_n == pattern_q);
        hist_d  = hist_n;
        d_out_d = hit;
        fill_d  = (hit && !OVERLAP) ? FILL_START : fill_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= DEF_PATTERN;
      hist_q    <= '0;
      fill_q    <= FILL_START;
      d_out_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      d_out_q   <= d_out_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .cnt   (bus.match_cnt)
  );

  assign bus.d_out   = d_out_q;
  assign bus.p_state = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations share one stimulus stream and are
// compared each cycle against a bit-log reference model, plus directed end-point checks.
module tb_seq_detect_param;

  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         din_valid, din, pat_load, cnt_clr;
  logic [L-1:0] pat_in;

  always #5 clk = ~clk;

  seq_detect_param_if #(.SEQ_LEN(L), .CNT_W(8)) if_ov  ();
  seq_detect_param_if #(.SEQ_LEN(L), .CNT_W(8)) if_nov ();
  seq_detect_param_if #(.SEQ_LEN(L), .CNT_W(2)) if_sat ();

  assign if_ov.din_valid  = din_valid;
  assign if_ov.din        = din;
  assign if_ov.pat_load   = pat_load;
  assign if_ov.pat_in     = pat_in;
  assign if_ov.cnt_clr    = cnt_clr;
  assign if_nov.din_valid = din_valid;
  assign if_nov.din       = din;
  assign if_nov.pat_load  = pat_load;
  assign if_nov.pat_in    = pat_in;
  assign if_nov.cnt_clr   = cnt_clr;
  assign if_sat.din_valid = din_valid;
  assign if_sat.din       = din;
  assign if_sat.pat_load  = pat_load;
  assign if_sat.pat_in    = pat_in;
  assign if_sat.cnt_clr   = cnt_clr;

  seq_detect_param #(.SEQ_LEN(L), .DEF_PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .bus(if_ov.slave));
  seq_detect_param #(.SEQ_LEN(L), .DEF_PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .reset(reset), .bus(if_nov.slave));
  seq_detect_param #(.SEQ_LEN(L), .DEF_PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(if_sat.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: log of every sampled bit; each config tracks where its usable history
  // starts. Index 0 = overlap/8-bit, 1 = non-overlap/8-bit, 2 = overlap/2-bit counter.
  bit           log_q[$];
  int           start  [3];
  bit           exp_d  [3];
  int           exp_cnt[3];
  int           exp_fill[3];
  logic [L-1:0] m_pattern;

  function automatic bit ov(input int k);
    return k != 1;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 2) ? 3 : 255;
  endfunction

  function automatic bit tail_matches();
    for (int i = 0; i < L; i++) begin
      if (log_q[log_q.size() - L + i] != m_pattern[L-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit hit[3];
    for (int k = 0; k < 3; k++) hit[k] = 1'b0;
    if (reset) begin
      m_pattern = 4'b1001;
      for (int k = 0; k < 3; k++) begin
        start[k]   = log_q.size();
        exp_d[k]   = 1'b0;
        exp_cnt[k] = 0;
      end
    end else begin
      if (pat_load) begin
        m_pattern = pat_in;
        for (int k = 0; k < 3; k++) begin
          start[k] = log_q.size();
          exp_d[k] = 1'b0;
        end
      end else if (din_valid) begin
        log_q.push_back(din);
        for (int k = 0; k < 3; k++) begin
          hit[k]   = ((log_q.size() - start[k]) >= L) && tail_matches();
          exp_d[k] = hit[k];
          if (hit[k] && !ov(k)) start[k] = log_q.size();
        end
      end else begin
        for (int k = 0; k < 3; k++) exp_d[k] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (cnt_clr) exp_cnt[k] = 0;
        else if (hit[k] && exp_cnt[k] < cnt_max(k)) exp_cnt[k]++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      exp_fill[k] = log_q.size() - start[k];
      if (exp_fill[k] > L) exp_fill[k] = L;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ov d_out",      32'(if_ov.d_out),      32'(exp_d[0]));
    check("ov match_cnt",  32'(if_ov.match_cnt),  32'(exp_cnt[0]));
    check("ov p_state",    32'(if_ov.p_state),    32'(exp_fill[0]));
    check("nov d_out",     32'(if_nov.d_out),     32'(exp_d[1]));
    check("nov match_cnt", 32'(if_nov.match_cnt), 32'(exp_cnt[1]));
    check("nov p_state",   32'(if_nov.p_state),   32'(exp_fill[1]));
    check("sat d_out",     32'(if_sat.d_out),     32'(exp_d[2]));
    check("sat match_cnt", 32'(if_sat.match_cnt), 32'(exp_cnt[2]));
    check("sat p_state",   32'(if_sat.p_state),   32'(exp_fill[2]));
  endtask

  task automatic step(input logic r, input logic v, input logic d, input logic ld,
                      input logic [L-1:0] pin, input logic clr);
    reset     = r;
    din_valid = v;
    din       = d;
    pat_load  = ld;
    pat_in    = pin;
    cnt_clr   = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic bit_in(input logic d);
    step(1'b0, 1'b1, d, 1'b0, '0, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic rst();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [6:0]  s7;
    logic [12:0] s13;
    logic [L-1:0] p4;
    m_pattern = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      start[k] = 0; exp_d[k] = 1'b0; exp_cnt[k] = 0; exp_fill[k] = 0;
    end
    rst();
    check("reset p_state", 32'(if_ov.p_state), 32'd0);

    // Overlapping vs non-overlapping on 1001001.
    rst();
    s7 = 7'b1001001;
    for (int i = 6; i >= 0; i--) bit_in(s7[i]);
    check("t1 ov cnt",      32'(if_ov.match_cnt),  32'd2);
    check("t1 nov cnt",     32'(if_nov.match_cnt), 32'd1);
    check("t1 nov p_state", 32'(if_nov.p_state),   32'd3);

    // Gaps between valid bits hold history.
    rst();
    bit_in(1'b1); gap(); gap(); bit_in(1'b0); gap(); bit_in(1'b0); gap();
    check("t3 p_state held", 32'(if_ov.p_state), 32'd3);
    bit_in(1'b1);
    check("t3 pulse", 32'(if_ov.d_out), 32'd1);
    gap();
    check("t3 pulse width", 32'(if_ov.d_out), 32'd0);

    // Pattern reload with a concurrent (dropped) bit.
    rst();
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
    check("t4 p_state after load", 32'(if_ov.p_state), 32'd0);
    p4 = 4'b1101;
    for (int i = 3; i >= 0; i--) bit_in(p4[i]);
    check("t4 pulse", 32'(if_ov.d_out), 32'd1);

    // Reset mid-stream discards earlier bits.
    rst();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
    rst();
    bit_in(1'b1);
    check("t5 no pulse", 32'(if_ov.d_out),     32'd0);
    check("t5 p_state",  32'(if_ov.p_state),   32'd1);
    check("t5 cnt",      32'(if_ov.match_cnt), 32'd0);

    // Counter saturation and clear-on-hit.
    rst();
    s13 = 13'b1001001001001;
    for (int i = 12; i >= 0; i--) bit_in(s13[i]);
    check("t6 ov cnt",  32'(if_ov.match_cnt),  32'd4);
    check("t6 sat cnt", 32'(if_sat.match_cnt), 32'd3);
    bit_in(1'b0); bit_in(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("t6 clr on hit cnt",   32'(if_sat.match_cnt), 32'd0);
    check("t6 clr on hit pulse", 32'(if_sat.d_out),     32'd1);

    // Randomised traffic with occasional reloads, clears and resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 59) == 0), 4'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
